// File: rtl/fft_pkg.sv
// Shared definitions for the 16-point FFT datapath.
//
// Contents:
//   DW, TW        - sample component width and twiddle component width
//   TW_RE, TW_IM  - W16^k twiddle ROM for k = 0..7, signed Q1.7 (+1.0 = 127)
//   sat_dw        - clamp a DW+1 bit signed value into the DW bit signed range
package fft_pkg;

  localparam int DW = 17;
  localparam int TW = 8;

  // Only the first half-turn of W16 is needed: stages use k = 0..7.
  localparam logic signed [TW-1:0] TW_RE [0:7] = '{
    8'sd127, 8'sd118, 8'sd91, 8'sd49, 8'sd0, -8'sd49, -8'sd91, -8'sd118
  };
  localparam logic signed [TW-1:0] TW_IM [0:7] = '{
    8'sd0, -8'sd49, -8'sd91, -8'sd118, -8'sd127, -8'sd118, -8'sd91, -8'sd49
  };

  // Overflow shows up as disagreement between the two top bits; the sign bit
  // then picks which rail to clamp to.
  function automatic logic signed [DW-1:0] sat_dw(input logic signed [DW:0] x);
    if (x[DW] != x[DW-1]) begin
      return x[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end
    return x[DW-1:0];
  endfunction

endpackage

// File: rtl/cmul17x8.sv
// Combinational complex multiplier partial products.
//
// Ports:
//   ar, ai - sample real / imaginary (DW bits signed)
//   wr, wi - twiddle real / imaginary (TW bits signed Q1.7)
//   p_rr = ar*wr, p_ii = ai*wi, p_ri = ar*wi, p_ir = ai*wr (multi16 scaling)
module cmul17x8 import fft_pkg::*; (
  input  logic signed [DW-1:0] ar,
  input  logic signed [DW-1:0] ai,
  input  logic signed [TW-1:0] wr,
  input  logic signed [TW-1:0] wi,
  output logic signed [DW-1:0] p_rr,
  output logic signed [DW-1:0] p_ii,
  output logic signed [DW-1:0] p_ri,
  output logic signed [DW-1:0] p_ir
);

  logic signed [DW-1:0] a_sel [4];
  logic signed [TW-1:0] b_sel [4];
  logic signed [DW-1:0] prod  [4];

  assign a_sel[0] = ar;  assign b_sel[0] = wr;
  assign a_sel[1] = ai;  assign b_sel[1] = wi;
  assign a_sel[2] = ar;  assign b_sel[2] = wi;
  assign a_sel[3] = ai;  assign b_sel[3] = wr;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_mul
      multi16 u_mul (
        .a (a_sel[gi]),
        .b (b_sel[gi]),
        .p (prod[gi])
      );
    end
  endgenerate

  assign p_rr = prod[0];
  assign p_ii = prod[1];
  assign p_ri = prod[2];
  assign p_ir = prod[3];

endmodule

// File: rtl/multi16.sv
// Signed 17x8 multiplier used throughout the FFT datapath.
//
// Ports:
//   a - 17-bit signed sample component
//   b - 8-bit signed Q1.7 twiddle component
//   p - floor(a*b / 128), low 17 bits (combinational)
module multi16 (
  input  logic signed [16:0] a,
  input  logic signed [7:0]  b,
  output logic signed [16:0] p
);

  logic [24:0] full;
  logic        unused_bits;

  // Low 25 bits of the product are identical for signed and unsigned
  // interpretation once both operands are sign-extended to 25 bits.
  assign full = {{8{a[16]}}, a} * {{17{b[7]}}, b};

  // Bits [23:7] are the arithmetic shift right by 7 truncated to 17 bits.
  assign p = full[23:7];

  assign unused_bits = ^{full[24], full[6:0]};

endmodule

// File: rtl/twiddle_mult_stage.sv
// Pipelined FFT twiddle-multiply stage: out = sat(in * W16^k).
//
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   in_valid / in_ready  - input handshake; in_ready = !out_valid | out_ready
//   in_sop               - first sample of a frame, forces twiddle index 0
//   in_re, in_im         - DW-bit signed sample
//   out_valid / out_ready- output handshake
//   out_sop              - in_sop delayed with its sample
//   out_re, out_im       - DW-bit signed saturated product
// Two register stages (partial products, then sum + saturation), so an
// accepted sample appears two cycles later when downstream is not stalling.
module twiddle_mult_stage #(
  parameter int DW     = 17,
  parameter int TW     = 8,
  parameter int STRIDE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sop,
  input  logic signed [DW-1:0] in_re,
  input  logic signed [DW-1:0] in_im,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sop,
  output logic signed [DW-1:0] out_re,
  output logic signed [DW-1:0] out_im
);
  import fft_pkg::*;

  localparam logic [2:0] STEP = 3'(STRIDE);

  logic                 advance;
  logic                 accept;
  logic [2:0]           k_reg, k_used, k_next;
  logic signed [TW-1:0] wr, wi;
  logic signed [DW-1:0] p_rr, p_ii, p_ri, p_ir;

  logic                 s1_valid_reg, s1_sop_reg;
  logic signed [DW-1:0] s1_rr_reg, s1_ii_reg, s1_ri_reg, s1_ir_reg;
  logic                 out_valid_reg, out_sop_reg;
  logic signed [DW-1:0] out_re_reg, out_im_reg;
  logic signed [DW:0]   re_sum, im_sum;

  // The whole pipeline moves as one unit: any stall at the output freezes
  // both stages and the index counter.
  assign advance  = !out_valid_reg || out_ready;
  assign in_ready = advance;
  assign accept   = in_valid && advance;

  assign k_used = in_sop ? 3'd0 : k_reg;
  assign k_next = accept ? (k_used + STEP) : k_reg;

  assign wr = TW_RE[k_used];
  assign wi = TW_IM[k_used];

  cmul17x8 u_cmul (
    .ar   (in_re),
    .ai   (in_im),
    .wr   (wr),
    .wi   (wi),
    .p_rr (p_rr),
    .p_ii (p_ii),
    .p_ri (p_ri),
    .p_ir (p_ir)
  );

  // One guard bit so the sum/difference cannot wrap before saturation.
  assign re_sum = {s1_rr_reg[DW-1], s1_rr_reg} - {s1_ii_reg[DW-1], s1_ii_reg};
  assign im_sum = {s1_ri_reg[DW-1], s1_ri_reg} + {s1_ir_reg[DW-1], s1_ir_reg};

  always_ff @(posedge clk) begin
    if (rst) begin
      k_reg <= 3'd0;
    end else begin
      k_reg <= k_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg  <= 1'b0;
      s1_sop_reg    <= 1'b0;
      s1_rr_reg     <= '0;
      s1_ii_reg     <= '0;
      s1_ri_reg     <= '0;
      s1_ir_reg     <= '0;
      out_valid_reg <= 1'b0;
      out_sop_reg   <= 1'b0;
      out_re_reg    <= '0;
      out_im_reg    <= '0;
    end else if (advance) begin
      // Bubbles carry valid=0 and sop=0; product registers may go stale.
      s1_valid_reg  <= accept;
      s1_sop_reg    <= accept && in_sop;
      s1_rr_reg     <= p_rr;
      s1_ii_reg     <= p_ii;
      s1_ri_reg     <= p_ri;
      s1_ir_reg     <= p_ir;
      out_valid_reg <= s1_valid_reg;
      out_sop_reg   <= s1_sop_reg;
      out_re_reg    <= sat_dw(re_sum);
      out_im_reg    <= sat_dw(im_sum);
    end
  end

  assign out_valid = out_valid_reg;
  assign out_sop   = out_sop_reg;
  assign out_re    = out_re_reg;
  assign out_im    = out_im_reg;

endmodule

// File: tb/tb_twiddle_mult_stage.sv
// Scoreboard bench for twiddle_mult_stage. Two instances run side by side on
// the same input stream: u_dut1 with STRIDE=1 and u_dut2 with STRIDE=2.
module tb_twiddle_mult_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic               in_valid  = 1'b0;
  logic               in_sop    = 1'b0;
  logic               out_ready = 1'b1;
  logic signed [16:0] in_re     = '0;
  logic signed [16:0] in_im     = '0;

  logic               ir1, ov1, os1, ir2, ov2, os2;
  logic signed [16:0] ore1, oim1, ore2, oim2;

  twiddle_mult_stage #(.DW(17), .TW(8), .STRIDE(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .in_sop(in_sop),
    .in_re(in_re), .in_im(in_im), .out_valid(ov1), .out_ready(out_ready),
    .out_sop(os1), .out_re(ore1), .out_im(oim1)
  );

  twiddle_mult_stage #(.DW(17), .TW(8), .STRIDE(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2), .in_sop(in_sop),
    .in_re(in_re), .in_im(in_im), .out_valid(ov2), .out_ready(out_ready),
    .out_sop(os2), .out_re(ore2), .out_im(oim2)
  );

  typedef struct {
    logic sop;
    int   re;
    int   im;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   checks   = 0;
  int   failures = 0;
  int   k1 = 0;
  int   k2 = 0;

  int wr_t[8] = '{127, 118, 91, 49, 0, -49, -91, -118};
  int wi_t[8] = '{0, -49, -91, -118, -127, -118, -91, -49};

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int trunc17(input int x);
    return (x <<< 15) >>> 15;
  endfunction

  function automatic int sat17(input int x);
    if (x > 65535) return 65535;
    if (x < -65536) return -65536;
    return x;
  endfunction

  // Reference: floor(a*w/128) wrapped to 17 bits, then saturated sum/diff.
  function automatic void model(input int re, input int im, input int k,
                                output int ore, output int oim);
    int prr, pii, pri, pir;
    prr = trunc17((re * wr_t[k]) >>> 7);
    pii = trunc17((im * wi_t[k]) >>> 7);
    pri = trunc17((re * wi_t[k]) >>> 7);
    pir = trunc17((im * wr_t[k]) >>> 7);
    ore = sat17(prr - pii);
    oim = sat17(pri + pir);
  endfunction

  // Drive one sample, wait until it is taken, and push the expected results.
  // h1/h2 select a hand-computed expectation instead of the model.
  task automatic send(input int re, input int im, input bit sop,
                      input bit h1, input int e1re, input int e1im,
                      input bit h2, input int e2re, input int e2im);
    exp_t e;
    int   idx, mre, mim, n;
    bit   acc;
    in_re    = re[16:0];
    in_im    = im[16:0];
    in_sop   = sop;
    in_valid = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = ir1;
      @(posedge clk);
      n++;
    end
    if (!acc) check("in_ready_timeout", 0, 1);
    idx = sop ? 0 : k1;
    model(re, im, idx, mre, mim);
    e.sop = sop; e.re = h1 ? e1re : mre; e.im = h1 ? e1im : mim;
    q1.push_back(e);
    k1 = (idx + 1) % 8;
    idx = sop ? 0 : k2;
    model(re, im, idx, mre, mim);
    e.sop = sop; e.re = h2 ? e2re : mre; e.im = h2 ? e2im : mim;
    q2.push_back(e);
    k2 = (idx + 2) % 8;
    #1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
  endtask

  task automatic send_m(input int re, input int im, input bit sop);
    send(re, im, sop, 1'b0, 0, 0, 1'b0, 0, 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q1.size() != 0 || q2.size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("drain_pending", q1.size() + q2.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // While stalled the output must already equal the head of the queue and
  // stay there; on a transfer the head is popped.
  task automatic mon(input int id, input logic ov, input logic os,
                     input logic signed [16:0] re, input logic signed [16:0] im);
    exp_t e;
    int   sz;
    if (!ov) return;
    sz = (id == 1) ? q1.size() : q2.size();
    if (sz == 0) begin
      check($sformatf("dut%0d_unexpected_output", id), 1, 0);
      return;
    end
    e = (id == 1) ? q1[0] : q2[0];
    if (!out_ready) begin
      check($sformatf("dut%0d_stall_re", id), int'(re), e.re);
      check($sformatf("dut%0d_stall_im", id), int'(im), e.im);
    end else begin
      if (id == 1) void'(q1.pop_front()); else void'(q2.pop_front());
      check($sformatf("dut%0d_sop", id), int'(os), int'(e.sop));
      check($sformatf("dut%0d_re", id), int'(re), e.re);
      check($sformatf("dut%0d_im", id), int'(im), e.im);
      $display("dut%0d out sop=%0d re=%0d im=%0d (req %0d %0d %0d)",
               id, os, re, im, e.sop, e.re, e.im);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(1, ov1, os1, ore1, oim1);
      mon(2, ov2, os2, ore2, oim2);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_out_valid", int'(ov1), 0);
    check("reset_out_sop", int'(os1), 0);
    check("reset_out_re", int'(ore1), 0);
    check("reset_out_im", int'(oim1), 0);
    check("reset_in_ready", int'(ir1), 1);
    check("reset_out_valid2", int'(ov2), 0);

    // k=0 product, 264*127/128 floors to 261
    send(264, 0, 1'b1, 1'b1, 261, 0, 1'b1, 261, 0);
    drain();

    // Fifth sample: STRIDE=1 -> k=4 (-j), STRIDE=2 -> k=0 after wrap
    send_m(1000, -500, 1'b1);
    send_m(-3000, 2000, 1'b0);
    send_m(12345, -6789, 1'b0);
    send_m(-1, 1, 1'b0);
    send(256, 0, 1'b0, 1'b1, 0, -254, 1'b1, 254, 0);
    drain();

    // Eighth sample saturates: k=7 for STRIDE=1, k=6 for STRIDE=2
    send_m(500, 600, 1'b1);
    send_m(-20000, 30000, 1'b0);
    send_m(65535, -65536, 1'b0);
    send_m(-65536, -65536, 1'b0);
    send_m(40000, 40000, 1'b0);
    send_m(-777, 4321, 1'b0);
    send_m(9, -9, 1'b0);
    send(65535, 65535, 1'b0, 1'b1, -35328, -65536, 1'b1, 0, -65536);
    drain();

    // Wrap/stride: (256,0) * W gives exactly (2*wr, 2*wi)
    for (int i = 0; i < 9; i++) begin
      send(256, 0, (i == 0),
           1'b1, 2 * wr_t[i % 8], 2 * wi_t[i % 8],
           1'b1, 2 * wr_t[(2 * i) % 8], 2 * wi_t[(2 * i) % 8]);
    end
    drain();

    // Backpressure: 20 back-to-back samples, 5-cycle stall mid-stream
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          send_m(i * 3001 - 30000, 25000 - i * 2777, (i == 0));
        end
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          #1;
          check("stall_in_ready", int'(ir1), 0);
          check("stall_in_ready2", int'(ir2), 0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two samples in flight
    send_m(100, 50, 1'b1);
    send_m(200, -50, 1'b0);
    rst = 1'b1;
    q1.delete();
    q2.delete();
    k1 = 0;
    k2 = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_flush_out_valid", int'(ov1), 0);
    check("rst_flush_out_valid2", int'(ov2), 0);
    check("rst_flush_in_ready", int'(ir1), 1);
    send(256, 0, 1'b0, 1'b1, 254, 0, 1'b1, 254, 0);
    drain();
    repeat (4) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/twiddle_mult_stage.md
Name: twiddle_mult_stage

Overview:
- Pipelined FFT twiddle-multiply stage. Accepts a stream of complex samples (17-bit Re/Im) on a valid/ready handshake.
- Internally sequences twiddle factors W16^k from a constant ROM and multiplies each sample by its twiddle using four instances of the existing multi16 17x8 multiplier.
- Outputs the saturated complex product. Sits between radix-2 butterfly stages of the 16-point FFT, directly consuming multi16 products.

Parameters:
- DW, 17: sample component width (signed two's complement).
- TW, 8: twiddle component width (signed Q1.7; +1.0 encoded as 127).
- STRIDE, 1: twiddle index increment per accepted sample, modulo 8 (1, 2 or 4 for successive FFT stages).

Ports:
- clk, in, 1: clock, all logic on rising edge.
- rst, in, 1: synchronous active-high reset.
- in_valid, in, 1: input sample valid.
- in_ready, out, 1: stage can accept a sample.
- in_sop, in, 1: first sample of a frame; forces twiddle index to 0 for this sample.
- in_re, in, DW: input real part.
- in_im, in, DW: input imaginary part.
- out_valid, out, 1: output product valid.
- out_ready, in, 1: downstream accepts.
- out_sop, out, 1: in_sop delayed alongside its sample.
- out_re, out, DW: product real part.
- out_im, out, DW: product imaginary part.

Behaviour:
- Reset: out_valid=0, out_sop=0, out_re=0, out_im=0, internal valids 0, twiddle index k=0. Reset mid-operation discards all in-flight samples; the cycle after rst deasserts, the stage is empty and in_ready=1.
- Pipeline: two register stages. advance = !out_valid | out_ready; in_ready = advance (combinational). All stage registers load only when advance=1.
- Latency: 2 cycles from accepted input to out_valid, with no backpressure. Throughput is 1 sample/cycle.
- Accept condition: in_valid & in_ready.
- Twiddle index per accepted sample: the used index is 0 if in_sop, else k. After use, k <= (used index + STRIDE) mod 8. k holds when nothing is accepted.
- Twiddle ROM, (wr, wi) for k=0..7: (127,0), (118,-49), (91,-91), (49,-118), (0,-127), (-49,-118), (-91,-91), (-118,-49).
- Stage 1 registers the four multi16 outputs: p_rr=ar*wr, p_ii=ai*wi, p_ri=ar*wi, p_ir=ai*wr.
  - Each product is the full 25-bit signed product, arithmetic right shift by 7 (floor), then the low 17 bits. This is multi16 semantics.
  - Stage 1 also registers sop and valid.
- Stage 2: re = p_rr - p_ii, im = p_ri + p_ir, both computed at 18 bits and saturated to [-65536, 65535]. Results are registered to out_re/out_im with out_valid and out_sop.
- Backpressure: while out_valid=1 and out_ready=0, all registers and k hold, and outputs stay stable. No sample is lost or duplicated, and order is preserved.
- Simultaneous in_sop and wrap: in_sop has priority over k.
- Bubbles: when advance=1 and no input is accepted, a stage-1 bubble is inserted (valid=0). Data registers may hold stale values when valid=0.

Decomposition:
- Shared package fft_pkg:
  - DW and TW constants.
  - Twiddle ROM constant array (8 entries of wr/wi).
  - 18-to-17-bit saturation function.
- Sub-module cmul17x8: combinational complex multiplier.
  - Instantiates four multi16 and produces p_rr, p_ii, p_ri, p_ir.
  - twiddle_mult_stage owns the handshake, pipeline registers, index counter and saturation.

Test Plan:
1. k=0 product: in_sop=1, in_re=264, in_im=0, out_ready=1 -> 2 cycles later out_valid=1, out_sop=1, out_re=261, out_im=0.
2. -j twiddle: frame of 5 samples with sop on the first, the fifth being (256,0) -> fifth output: out_re=0, out_im=-254.
3. Saturation at k=7: eighth sample of a frame = (65535,65535) -> out_re=-35328, out_im=-65536 (saturated).
4. Backpressure: 20 back-to-back inputs, out_ready low for 5 cycles mid-stream -> in_ready low during the stall, outputs held stable, all 20 results in order matching the reference model.
5. Wrap and stride: 9 samples, sop only on the first, STRIDE=1 -> ninth uses k=0. Repeat with STRIDE=2 -> indices 0,2,4,6,0,...
6. Reset mid-frame: rst high for 1 cycle with 2 samples in flight -> next cycle out_valid=0, no stale outputs appear, and the next non-sop sample uses k=0.
